// File: rtl/tick_sequencer_pkg.sv
// Shared types and constants for the per-tick storage sequencer.
// State/phase enums, mode codes, direction encodings, step search helper.
package tick_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_SWEEP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_CALC,
    PH_LATCH,
    PH_WRITE
  } phase_t;

  localparam logic [3:0] MODE_IDLE  = 4'b0000;
  localparam logic [3:0] MODE_SWEEP = 4'b1111;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [1:0] P1_RST_DIR = DIR_DOWN;
  localparam logic [1:0] P2_RST_DIR = DIR_UP;

  // pl=1 selects player 2, proj=1 selects the projectile object
  function automatic logic [3:0] step_mode(
    input logic pl,
    input logic proj
  );
    return {1'b0, pl, proj, 1'b1};
  endfunction

  // Lowest active step index >= from; bit 2 set means none left
  function automatic logic [2:0] first_from(
    input logic [3:0] act,
    input logic [2:0] from
  );
    logic [2:0] r;
    r = 3'b100;
    for (int i = 3; i >= 0; i--) begin
      if (act[i] && 3'(i) >= from) begin
        r = {1'b0, 2'(i)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/player_req_latch.sv
// One player's move/fire request latches, tracked tank dir, projectile state.
// Ports: req/dir/fire in; step strobes from the sequencer; pending flags and dirs out.
module player_req_latch
  import tick_sequencer_pkg::*;
#(
  parameter int         PROJ_RANGE = 15,
  parameter logic [1:0] RST_DIR    = 2'b00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] dir,
  input  logic       fire,
  input  logic       tank_busy,
  input  logic       tank_write,
  input  logic [1:0] wdir,
  input  logic       proj_calc,
  input  logic       proj_write,
  output logic       move_pend,
  output logic [1:0] move_dir,
  output logic       proj_pend,
  output logic [1:0] proj_dir
);

  logic       pend_q;
  logic [1:0] mdir_q;
  logic       rearm_q;
  logic [1:0] tdir_q;
  logic       fire_q;
  logic       fly_q;
  logic [1:0] pdir_q;
  logic [7:0] rng_q;

  // A request seen while this tank's step is in progress was not
  // part of the data already issued, so it stays pending (rearm).
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q  <= 1'b0;
      mdir_q  <= DIR_UP;
      rearm_q <= 1'b0;
      tdir_q  <= RST_DIR;
      fire_q  <= 1'b0;
      fly_q   <= 1'b0;
      pdir_q  <= DIR_UP;
      rng_q   <= '0;
    end else begin
      if (req) begin
        mdir_q <= dir;
      end
      if (tank_write) begin
        pend_q  <= req | rearm_q;
        rearm_q <= 1'b0;
        tdir_q  <= wdir;
      end else begin
        if (req) begin
          pend_q <= 1'b1;
        end
        if (req && tank_busy) begin
          rearm_q <= 1'b1;
        end
      end
      if (proj_calc && fire_q) begin
        fire_q <= 1'b0;
        fly_q  <= 1'b1;
        rng_q  <= 8'(PROJ_RANGE);
        pdir_q <= tdir_q;
      end else if (fire && !fly_q) begin
        fire_q <= 1'b1;
      end
      if (proj_write) begin
        rng_q <= rng_q - 8'd1;
        if (rng_q == 8'd1) begin
          fly_q <= 1'b0;
        end
      end
    end
  end

  assign move_pend = pend_q;
  assign move_dir  = mdir_q;
  assign proj_pend = fly_q | fire_q;
  // During a launching CALC the new dir is not registered yet
  assign proj_dir  = fire_q ? tdir_q : pdir_q;

endmodule

// File: rtl/tick_sequencer.sv
// Per-game-tick scheduler: tank/projectile steps in alternating order, then RAM sweep.
// Ports: clk, reset, tick, p1/p2 req/dir/fire in; mode, load_out, address, data, busy, frame_done, overrun out.
module tick_sequencer
  import tick_sequencer_pkg::*;
#(
  parameter int SWEEP_LEN  = 256,
  parameter int PROJ_RANGE = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       p1_req,
  input  logic [1:0] p1_dir,
  input  logic       p1_fire,
  input  logic       p2_req,
  input  logic [1:0] p2_dir,
  input  logic       p2_fire,
  output logic [3:0] mode,
  output logic       load_out,
  output logic [7:0] address,
  output logic [7:0] data,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] overrun
);

  localparam logic [7:0] LAST = 8'(SWEEP_LEN - 1);

  state_t     state_q, state_d;
  phase_t     phase_q, phase_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] addr_q, addr_d;
  logic       first_q, first_d;
  logic       pend_q, pend_d;
  logic [7:0] ovr_q, ovr_d;
  logic [1:0] sdata_q, sdata_d;

  logic [1:0] mv, pj;
  logic [1:0] mdir [2];
  logic [1:0] pdir [2];
  logic       pl, is_proj, in_step, go;
  logic [1:0] cur_dir;
  logic [3:0] act;
  logic [2:0] from, nx;
  logic [1:0] t_busy, t_wr, p_calc, p_wr;

  // Step order for first player f: F tank, F proj, S tank, S proj
  function automatic logic [3:0] act_for(
    input logic       f,
    input logic [1:0] m,
    input logic [1:0] p
  );
    return {p[!f], m[!f], p[f], m[f]};
  endfunction

  player_req_latch #(
    .PROJ_RANGE(PROJ_RANGE),
    .RST_DIR   (P1_RST_DIR)
  ) u_p1 (
    .clk       (clk),
    .reset     (reset),
    .req       (p1_req),
    .dir       (p1_dir),
    .fire      (p1_fire),
    .tank_busy (t_busy[0]),
    .tank_write(t_wr[0]),
    .wdir      (sdata_q),
    .proj_calc (p_calc[0]),
    .proj_write(p_wr[0]),
    .move_pend (mv[0]),
    .move_dir  (mdir[0]),
    .proj_pend (pj[0]),
    .proj_dir  (pdir[0])
  );

  player_req_latch #(
    .PROJ_RANGE(PROJ_RANGE),
    .RST_DIR   (P2_RST_DIR)
  ) u_p2 (
    .clk       (clk),
    .reset     (reset),
    .req       (p2_req),
    .dir       (p2_dir),
    .fire      (p2_fire),
    .tank_busy (t_busy[1]),
    .tank_write(t_wr[1]),
    .wdir      (sdata_q),
    .proj_calc (p_calc[1]),
    .proj_write(p_wr[1]),
    .move_pend (mv[1]),
    .move_dir  (mdir[1]),
    .proj_pend (pj[1]),
    .proj_dir  (pdir[1])
  );

  assign pl      = first_q ^ idx_q[1];
  assign is_proj = idx_q[0];
  assign in_step = (state_q == S_STEP);
  assign cur_dir = is_proj ? pdir[pl] : mdir[pl];

  always_comb begin
    t_busy = '0;
    t_wr   = '0;
    p_calc = '0;
    p_wr   = '0;
    t_busy[pl] = in_step && !is_proj && phase_q != PH_WRITE;
    t_wr[pl]   = in_step && !is_proj && phase_q == PH_WRITE;
    p_calc[pl] = in_step && is_proj && phase_q == PH_CALC;
    p_wr[pl]   = in_step && is_proj && phase_q == PH_WRITE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      phase_q <= PH_CALC;
      idx_q   <= '0;
      addr_q  <= '0;
      first_q <= 1'b0;
      pend_q  <= 1'b0;
      ovr_q   <= '0;
      sdata_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      first_q <= first_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      sdata_q <= sdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    first_d = first_q;
    sdata_d = sdata_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    go      = 1'b0;
    // DONE restarts with the toggled first player
    act  = act_for((state_q == S_DONE) ? !first_q : first_q,
                   mv, pj);
    from = in_step ? 3'(idx_q) + 3'd1 : 3'd0;
    nx   = first_from(act, from);
    unique case (state_q)
      S_IDLE: go = tick;
      S_STEP: begin
        unique case (phase_q)
          PH_CALC: begin
            sdata_d = cur_dir;
            phase_d = PH_LATCH;
          end
          PH_LATCH: phase_d = PH_WRITE;
          PH_WRITE: go = 1'b1;
          default:  phase_d = PH_CALC;
        endcase
      end
      S_SWEEP: begin
        addr_d = addr_q + 8'd1;
        if (addr_q == LAST) begin
          state_d = S_DONE;
          addr_d  = '0;
        end
      end
      S_DONE: begin
        first_d = !first_q;
        go      = pend_q | tick;
        if (!go) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (go) begin
      if (nx[2]) begin
        state_d = S_SWEEP;
        addr_d  = '0;
      end else begin
        state_d = S_STEP;
        idx_d   = nx[1:0];
        phase_d = PH_CALC;
      end
    end
    // A DONE-cycle tick restarts directly unless one is already held
    unique case (1'b1)
      state_q == S_IDLE: pend_d = 1'b0;
      state_q == S_DONE: pend_d = pend_q & tick;
      default: begin
        pend_d = pend_q | tick;
        if (tick && pend_q && ovr_q != 8'hFF) begin
          ovr_d = ovr_q + 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    mode     = MODE_IDLE;
    load_out = 1'b0;
    address  = '0;
    data     = '0;
    unique case (state_q)
      S_STEP: begin
        mode     = step_mode(pl, is_proj);
        load_out = (phase_q == PH_LATCH);
        data     = {6'b0, (phase_q == PH_CALC) ? cur_dir : sdata_q};
      end
      S_SWEEP: begin
        mode    = MODE_SWEEP;
        address = addr_q;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);
  assign overrun    = ovr_q;

endmodule
